micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 65 ++++++
 rtl/micro_sequencer_if.sv | 31 +++
 rtl/opcode_decode.sv | 33 +++
 rtl/micro_sequencer.sv | 89 ++++++++
 tb/tb_micro_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer and the control unit it drives.
// Holds the state-code map, the opcode map, the decoder result type and small
// helpers that classify state codes.
package micro_sequencer_pkg;

   localparam int unsigned STATE_WIDTH = 6;
   localparam int unsigned OPC_WIDTH   = 4;

   // LDR1 steps are StLdrA*, LDR2 steps are StLdrB*.
   typedef enum logic [STATE_WIDTH-1:0] {
      StIdle   = 6'd0,
      StFetch1 = 6'd1,
      StFetch2 = 6'd2,
      StFetch3 = 6'd3,
      StFetch4 = 6'd4,
      StFetch5 = 6'd5,
      StFetch6 = 6'd6,
      StLdrA1  = 6'd7,
      StLdrA2  = 6'd8,
      StLdrA3  = 6'd9,
      StLdrA4  = 6'd10,
      StLdrB1  = 6'd11,
      StLdrB2  = 6'd12,
      StLdrB3  = 6'd13,
      StLdrB4  = 6'd14,
      StStac1  = 6'd15,
      StStac2  = 6'd16,
      StStac3  = 6'd17,
      StStac4  = 6'd18,
      StAdd1   = 6'd19,
      StAdd2   = 6'd20,
      StMul1   = 6'd21,
      StMul2   = 6'd22,
      StFinish = 6'd23
   } state_e;

   typedef enum logic [OPC_WIDTH-1:0] {
      OpNop  = 4'h0,
      OpLdr1 = 4'h1,
      OpLdr2 = 4'h2,
      OpStac = 4'h3,
      OpAdd  = 4'h4,
      OpMul  = 4'h5,
      OpEnd  = 4'hF
   } opcode_e;

   typedef struct packed {
      state_e first_state;
      logic   legal;
      logic   is_end;
      logic   is_nop;
   } decode_t;

   // Final step of an instruction: retires it and returns to FETCH1.
   function automatic logic is_retire_state(state_e s);
      return (s == StLdrA4) || (s == StLdrB4) || (s == StStac4) ||
             (s == StAdd2)  || (s == StMul2);
   endfunction

   // Any code outside the defined map (24..63).
   function automatic logic is_unused_state(state_e s);
      return s > StFinish;
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer <-> control-unit bundle.
//   master: drives start, stall, opcode; observes state and status.
//   slave : the sequencer; drives state, busy, done, error, instr_count.
interface micro_sequencer_if
   import micro_sequencer_pkg::*;
#(
   parameter int unsigned STATE_W = STATE_WIDTH,
   parameter int unsigned OPC_W   = OPC_WIDTH,
   parameter int unsigned CNT_W   = 8
) ();

   logic               start;
   logic               stall;
   logic [OPC_W-1:0]   opcode;
   logic [STATE_W-1:0] state;
   logic               busy;
   logic               done;
   logic               error;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      output start, stall, opcode,
      input  state, busy, done, error, instr_count
   );

   modport slave (
      input  start, stall, opcode,
      output state, busy, done, error, instr_count
   );

endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode decoder.
//   opcode_i : opcode field from the instruction register
//   dec_o    : {first_state, legal, is_end, is_nop}
// NOP maps to FETCH1; END and every illegal code map to FINISH, so the
// sequencer can always take first_state straight out of FETCH6.
module opcode_decode
   import micro_sequencer_pkg::*;
(
   input  logic [OPC_WIDTH-1:0] opcode_i,
   output decode_t              dec_o
);

   always_comb begin
      dec_o.first_state = StFinish;
      dec_o.legal       = 1'b1;
      dec_o.is_end      = 1'b0;
      dec_o.is_nop      = 1'b0;
      case (opcode_i)
         OpNop: begin
            dec_o.first_state = StFetch1;
            dec_o.is_nop      = 1'b1;
         end
         OpLdr1: dec_o.first_state = StLdrA1;
         OpLdr2: dec_o.first_state = StLdrB1;
         OpStac: dec_o.first_state = StStac1;
         OpAdd:  dec_o.first_state = StAdd1;
         OpMul:  dec_o.first_state = StMul1;
         OpEnd:  dec_o.is_end      = 1'b1;
         default: dec_o.legal      = 1'b0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: steps through FETCH1..6, then the micro-steps of the
// decoded instruction, counting retired instructions (saturating).
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : start/stall/opcode in; state/busy/done/error/instr_count out
// All outputs are registers or decodes of the registered state.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int unsigned STATE_W = STATE_WIDTH,
   parameter int unsigned OPC_W   = OPC_WIDTH,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   micro_sequencer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             error_q, error_d;
   logic             retire;
   decode_t          dec;
   logic [OPC_W-1:0] opc;

   assign opc = bus.opcode;

   opcode_decode u_opcode_decode (
      .opcode_i (OPC_WIDTH'(opc)),
      .dec_o    (dec)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      error_d = error_q;
      retire  = 1'b0;
      if (!bus.stall) begin
         case (state_q)
            StIdle: begin
               // A new program clears the sticky status.
               if (bus.start) begin
                  state_d = StFetch1;
                  count_d = '0;
                  error_d = 1'b0;
               end
            end
            StFetch6: begin
               state_d = dec.first_state;
               retire  = dec.is_nop;
               if (!dec.legal) error_d = 1'b1;
            end
            StFinish: begin
               if (!bus.start) state_d = StIdle;
            end
            default: begin
               if (is_unused_state(state_q)) begin
                  state_d = StIdle;
                  error_d = 1'b1;
               end else if (is_retire_state(state_q)) begin
                  state_d = StFetch1;
                  retire  = 1'b1;
               end else begin
                  state_d = state_e'(state_q + 6'd1);
               end
            end
         endcase
         if (retire && (count_q != '1)) count_d = count_q + 1'b1;
      end
   end

   assign bus.state       = STATE_W'(state_q);
   assign bus.busy        = (state_q != StIdle) && (state_q != StFinish);
   assign bus.done        = (state_q == StFinish);
   assign bus.error       = error_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the stimulus process steps a
// program-level reference model and queues the expected outputs for the
// following edge; the monitor pops and compares one entry per clock.
module tb_micro_sequencer;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   micro_sequencer_if #(.STATE_W(6), .OPC_W(4), .CNT_W(8)) bus_if ();

   micro_sequencer #(.STATE_W(6), .OPC_W(4), .CNT_W(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   typedef struct {
      int state;
      int busy;
      int done;
      int error;
      int count;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: program phase plus step within that phase.
   typedef enum int {MIdle, MFetch, MExec, MFin} mmode_e;
   mmode_e m_mode;
   int     m_fstep, m_base, m_len, m_istep, m_cnt, m_err;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_mode  = MIdle;
      m_fstep = 0;
      m_istep = 0;
      m_cnt   = 0;
      m_err   = 0;
   endfunction

   function automatic void m_retire();
      if (m_cnt < 255) m_cnt++;
      m_mode  = MFetch;
      m_fstep = 1;
   endfunction

   function automatic void m_step(input bit st, input bit sl, input int op);
      if (sl) return;
      case (m_mode)
         MIdle: if (st) begin
            m_mode = MFetch; m_fstep = 1; m_cnt = 0; m_err = 0;
         end
         MFetch: begin
            if (m_fstep < 6) m_fstep++;
            else begin
               case (op)
                  0:  m_retire();
                  1:  begin m_mode = MExec; m_base = 7;  m_len = 4; m_istep = 1; end
                  2:  begin m_mode = MExec; m_base = 11; m_len = 4; m_istep = 1; end
                  3:  begin m_mode = MExec; m_base = 15; m_len = 4; m_istep = 1; end
                  4:  begin m_mode = MExec; m_base = 19; m_len = 2; m_istep = 1; end
                  5:  begin m_mode = MExec; m_base = 21; m_len = 2; m_istep = 1; end
                  15: m_mode = MFin;
                  default: begin m_mode = MFin; m_err = 1; end
               endcase
            end
         end
         MExec: begin
            if (m_istep < m_len) m_istep++;
            else m_retire();
         end
         MFin: if (!st) m_mode = MIdle;
         default: m_mode = MIdle;
      endcase
   endfunction

   function automatic exp_t m_snapshot();
      exp_t e;
      case (m_mode)
         MIdle:   e.state = 0;
         MFetch:  e.state = m_fstep;
         MExec:   e.state = m_base + m_istep - 1;
         default: e.state = 23;
      endcase
      e.busy  = (m_mode == MFetch || m_mode == MExec) ? 1 : 0;
      e.done  = (m_mode == MFin) ? 1 : 0;
      e.error = m_err;
      e.count = m_cnt;
      return e;
   endfunction

   // One clock of stimulus; the queued entry is what the next edge must produce.
   task automatic cycle(input bit rn, input bit st, input bit sl, input logic [3:0] op);
      @(posedge clock);
      #2;
      reset_n       = rn;
      bus_if.start  = st;
      bus_if.stall  = sl;
      bus_if.opcode = op;
      if (!rn) begin
         #1;
         chk("async_rst_state", int'(bus_if.state), 0);
         chk("async_rst_busy",  int'(bus_if.busy), 0);
         chk("async_rst_done",  int'(bus_if.done), 0);
         chk("async_rst_error", int'(bus_if.error), 0);
         chk("async_rst_count", int'(bus_if.instr_count), 0);
         m_reset();
      end else begin
         m_step(st, sl, int'(op));
      end
      exp_q.push_back(m_snapshot());
   endtask

   // Runs one instruction from FETCH1 (or mid-instruction) until it retires or ends.
   task automatic exec_op(input logic [3:0] op);
      int guard = 0;
      do begin
         cycle(1'b1, 1'b0, 1'b0, op);
         guard++;
      end while (!(m_mode == MFetch && m_fstep == 1) && m_mode != MFin && guard < 20);
      chk("exec_op_bound", (guard < 20) ? 1 : 0, 1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(bus_if.state), e.state);
            chk("busy",  int'(bus_if.busy), e.busy);
            chk("done",  int'(bus_if.done), e.done);
            chk("error", int'(bus_if.error), e.error);
            chk("count", int'(bus_if.instr_count), e.count);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset_n       = 1'b0;
      bus_if.start  = 1'b0;
      bus_if.stall  = 1'b0;
      bus_if.opcode = 4'h0;
      m_reset();
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 4'h0);

      // ADD after start: 1..6, 19, 20, 1; then NOP and END.
      cycle(1'b1, 1'b1, 1'b0, 4'h0);
      exec_op(4'h4);
      exec_op(4'h0);
      exec_op(4'hF);
      // FINISH holds on start, leaves on start=0 keeping the count.
      repeat (2) cycle(1'b1, 1'b1, 1'b0, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b1, 1'b1, 4'h0);     // stalled IDLE ignores start
      cycle(1'b1, 1'b1, 1'b0, 4'h0);

      // LDR1, LDR2, MUL, END -> FINISH with count 3.
      exec_op(4'h1);
      exec_op(4'h2);
      exec_op(4'h5);
      exec_op(4'hF);
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b1, 1'b0, 4'h0);

      // Illegal opcode; error survives FINISH->IDLE, clears on restart.
      exec_op(4'h7);
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b1, 1'b0, 4'h0);

      // STAC stalled three cycles in STAC2.
      repeat (7) cycle(1'b1, 1'b0, 1'b0, 4'h3);
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 4'h3);
      exec_op(4'h3);

      // Reset in LDR1_3 abandons the instruction.
      repeat (8) cycle(1'b1, 1'b0, 1'b0, 4'h1);
      cycle(1'b0, 1'b0, 1'b0, 4'h1);
      cycle(1'b0, 1'b0, 1'b0, 4'h1);
      cycle(1'b1, 1'b1, 1'b0, 4'h0);

      // Saturation: more than 255 NOPs.
      repeat (258) exec_op(4'h0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] op;
         int         pick;
         pick = $urandom_range(0, 9);
         if (pick < 7)       op = 4'($urandom_range(0, 5));
         else if (pick == 7) op = 4'hF;
         else                op = 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 499) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), op);
      end

      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      repeat (2) @(posedge clock);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
